// File: rtl/instr_fetch_unit_pkg.sv
// Shared CPU definitions: fetch FSM encoding, instruction width and halt encoding.
// Pure declarations; no logic, no latency, no flow control.
package instr_fetch_unit_pkg;

    localparam int NB_INSTR_DEF = 32;
    localparam logic [NB_INSTR_DEF-1:0] HALT_INSTR_DEF = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } if_state_t;

endpackage

// File: rtl/instr_fetch_unit_instr_mem.sv
// Word-addressed instruction store: one synchronous write port, one combinational read port.
// Read is zero-latency, write lands on the next clk edge; no reset, no backpressure.
module instr_fetch_unit_instr_mem #(
    parameter int NB_INSTR  = 32,
    parameter int MEM_DEPTH = 256,
    parameter int NB_ADDR   = $clog2(MEM_DEPTH)
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [NB_ADDR-1:0]  wr_addr,
    input  logic [NB_INSTR-1:0] wr_data,
    input  logic [NB_ADDR-1:0]  rd_addr,
    output logic [NB_INSTR-1:0] rd_data
);

    logic [NB_INSTR-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, next-PC select and idle/run/halted control; IF_STEP_EN gates advance on i_step.
// instr/pc/pc_next are combinational from the PC; redirect lands next edge; i_stall holds the PC with o_valid low.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                     NB_INSTR   = NB_INSTR_DEF,
    parameter int                     NB_PC      = 32,
    parameter int                     MEM_DEPTH  = 256,
    parameter logic [NB_PC-1:0]       RESET_PC   = 32'h0000_0000,
    parameter logic [NB_INSTR-1:0]    HALT_INSTR = HALT_INSTR_DEF
) (
    input  logic                clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                i_step,
    input  logic                i_stall,
    input  logic                i_redirect,
    input  logic [NB_PC-1:0]    i_redirect_pc,
    input  logic                i_wr_en,
    input  logic [NB_PC-1:0]    i_wr_addr,
    input  logic [NB_INSTR-1:0] i_wr_data,
    output logic [NB_INSTR-1:0] o_instr,
    output logic [NB_PC-1:0]    o_pc,
    output logic [NB_PC-1:0]    o_pc_next,
    output logic                o_valid,
    output logic                o_halt
);

    localparam int NB_ADDR = $clog2(MEM_DEPTH);

    if_state_t        state, state_nxt;
    logic [NB_PC-1:0] pc, pc_nxt, pc_plus4;
    logic             step_ok;
    logic             advance;
    logic             redirect_take;
    logic             is_halt;
    logic             mem_wr_en;
    logic             unused_bits;

`ifdef IF_STEP_EN
    assign step_ok     = i_step;
    assign unused_bits = ^{i_wr_addr[1:0], i_wr_addr[NB_PC-1:NB_ADDR+2]};
`else
    assign step_ok     = 1'b1;
    assign unused_bits = ^{i_step, i_wr_addr[1:0], i_wr_addr[NB_PC-1:NB_ADDR+2]};
`endif

    // Loader may only touch the program while nothing is being fetched.
    assign mem_wr_en = i_wr_en && (state != RUN);

    instr_fetch_unit_instr_mem #(
        .NB_INSTR  (NB_INSTR),
        .MEM_DEPTH (MEM_DEPTH),
        .NB_ADDR   (NB_ADDR)
    ) u_instr_mem (
        .clk     (clk),
        .wr_en   (mem_wr_en),
        .wr_addr (i_wr_addr[2 +: NB_ADDR]),
        .wr_data (i_wr_data),
        .rd_addr (pc[2 +: NB_ADDR]),
        .rd_data (o_instr)
    );

    assign pc_plus4      = pc + NB_PC'(4);
    assign is_halt       = (o_instr == HALT_INSTR);
    assign advance       = (state == RUN) && !i_stall && step_ok;
    assign redirect_take = (state == RUN) && i_redirect && step_ok;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            IDLE, HALTED: begin
                if (i_start) begin
                    state_nxt = RUN;
                    pc_nxt    = RESET_PC;
                end
            end
            RUN: begin
                // Redirect beats stall and halt: the current word is on the wrong path.
                if (redirect_take) begin
                    pc_nxt = i_redirect_pc;
                end else if (advance) begin
                    pc_nxt = pc_plus4;
                    if (is_halt) begin
                        state_nxt = HALTED;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                pc_nxt    = RESET_PC;
            end
        endcase
    end

    assign o_pc      = pc;
    assign o_pc_next = pc_plus4;
    assign o_valid   = advance;
    assign o_halt    = (state == HALTED);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: per-cycle vector table with an expectation queue, plus reset and step sequences.
module tb_instr_fetch_unit;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP  = 32'h0000_0013;

`ifdef IF_STEP_EN
    localparam logic STEP_DFLT = 1'b1;
`else
    localparam logic STEP_DFLT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start, step, stall, redir;
    logic [31:0] redir_pc;
    logic        wr_en;
    logic [31:0] wr_addr, wr_data;
    logic [31:0] instr, pc, pc_next;
    logic        valid, halt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        start, stall, redir;
        logic [31:0] rpc;
        logic        wr;
        logic [31:0] waddr, wdata;
        logic [31:0] pc;
        logic        v, h;
        logic        ci;
        logic [31:0] instr;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    instr_fetch_unit dut (
        .clk           (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_step        (step),
        .i_stall       (stall),
        .i_redirect    (redir),
        .i_redirect_pc (redir_pc),
        .i_wr_en       (wr_en),
        .i_wr_addr     (wr_addr),
        .i_wr_data     (wr_data),
        .o_instr       (instr),
        .o_pc          (pc),
        .o_pc_next     (pc_next),
        .o_valid       (valid),
        .o_halt        (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s[%0d] got=%h want=%h", name, idx, got, want);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic sl, input logic rd, input logic [31:0] rpc,
                                input logic w, input logic [31:0] wa, input logic [31:0] wd,
                                input logic [31:0] epc, input logic ev, input logic eh,
                                input logic ci, input logic [31:0] ei);
        vec_t r;
        r.start = st; r.stall = sl; r.redir = rd; r.rpc = rpc;
        r.wr = w; r.waddr = wa; r.wdata = wd;
        r.pc = epc; r.v = ev; r.h = eh; r.ci = ci; r.instr = ei;
        return r;
    endfunction

    // Drive one cycle's inputs, queue its expectation, then compare settled outputs before the next edge.
    task automatic drive(input vec_t v, input logic stp, input string tag, input int idx);
        vec_t e;
        @(negedge clk);
        start = v.start; stall = v.stall; redir = v.redir; redir_pc = v.rpc;
        wr_en = v.wr; wr_addr = v.waddr; wr_data = v.wdata; step = stp;
        exp_q.push_back(v);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".pc"}, idx, pc, e.pc);
        chk({tag, ".pc_next"}, idx, pc_next, e.pc + 32'd4);
        chk({tag, ".valid"}, idx, {31'd0, valid}, {31'd0, e.v});
        chk({tag, ".halt"}, idx, {31'd0, halt}, {31'd0, e.h});
        if (e.ci) chk({tag, ".instr"}, idx, instr, e.instr);
    endtask

    function automatic vec_t idle_v(input logic [31:0] epc, input logic ev, input logic eh);
        return mk(0, 0, 0, 0, 0, 0, 0, epc, ev, eh, 0, 0);
    endfunction

    initial begin
        rst = 1'b1; start = 0; step = STEP_DFLT; stall = 0; redir = 0; redir_pc = 0;
        wr_en = 0; wr_addr = 0; wr_data = 0;

        // Program load in IDLE
        vecs.push_back(mk(0,0,0,0,        1,32'h0,  NOP,  32'h0,0,0, 0,0));
        vecs.push_back(mk(0,0,0,0,        1,32'h4,  NOP,  32'h0,0,0, 0,0));
        vecs.push_back(mk(0,0,0,0,        1,32'h8,  NOP,  32'h0,0,0, 0,0));
        vecs.push_back(mk(0,0,0,0,        1,32'hC,  HALT, 32'h0,0,0, 0,0));
        vecs.push_back(mk(0,0,0,0,        1,32'h40, NOP,  32'h0,0,0, 0,0));
        vecs.push_back(mk(0,0,0,0,        1,32'h44, HALT, 32'h0,0,0, 0,0));
        vecs.push_back(mk(0,0,1,32'h80,   0,0,0,          32'h0,0,0, 1,NOP));
        vecs.push_back(mk(1,0,0,0,        0,0,0,          32'h0,0,0, 0,0));
        // Run to halt; RUN-time write and start are ignored
        vecs.push_back(mk(0,0,0,0,        0,0,0,          32'h0,1,0, 1,NOP));
        vecs.push_back(mk(0,0,0,0,        0,0,0,          32'h4,1,0, 0,0));
        vecs.push_back(mk(1,0,0,0,        1,32'h0,32'hDEADBEEF, 32'h8,1,0, 1,NOP));
        vecs.push_back(mk(0,0,0,0,        0,0,0,          32'hC,1,0, 1,HALT));
        vecs.push_back(idle_v(32'h10,0,1));
        vecs.push_back(idle_v(32'h10,0,1));
        // Restart with a two-cycle stall at 0x4
        vecs.push_back(mk(1,0,0,0,        0,0,0,          32'h10,0,1, 0,0));
        vecs.push_back(mk(0,0,0,0,        0,0,0,          32'h0,1,0, 1,NOP));
        vecs.push_back(mk(0,1,0,0,        0,0,0,          32'h4,0,0, 0,0));
        vecs.push_back(mk(0,1,0,0,        0,0,0,          32'h4,0,0, 0,0));
        vecs.push_back(mk(0,0,0,0,        0,0,0,          32'h4,1,0, 0,0));
        vecs.push_back(mk(0,0,0,0,        0,0,0,          32'h8,1,0, 0,0));
        vecs.push_back(mk(0,0,0,0,        0,0,0,          32'hC,1,0, 1,HALT));
        // HALTED writes are accepted
        vecs.push_back(mk(0,0,0,0,        1,32'h8, HALT,  32'h10,0,1, 0,0));
        vecs.push_back(mk(0,0,0,0,        1,32'h20,NOP,   32'h10,0,1, 0,0));
        // Redirect beats stall and the halt word at 0x8, then wrap at 0x400
        vecs.push_back(mk(1,0,0,0,        0,0,0,          32'h10,0,1, 0,0));
        vecs.push_back(mk(0,0,0,0,        0,0,0,          32'h0,1,0, 0,0));
        vecs.push_back(mk(0,0,0,0,        0,0,0,          32'h4,1,0, 0,0));
        vecs.push_back(mk(0,1,1,32'h40,   0,0,0,          32'h8,0,0, 1,HALT));
        vecs.push_back(mk(0,0,1,32'h400,  0,0,0,          32'h40,1,0, 1,NOP));
        vecs.push_back(mk(0,0,0,0,        0,0,0,          32'h400,1,0, 1,NOP));
        vecs.push_back(mk(0,0,0,0,        0,0,0,          32'h404,1,0, 1,NOP));
        vecs.push_back(mk(0,0,0,0,        0,0,0,          32'h408,1,0, 1,HALT));
        vecs.push_back(idle_v(32'h40C,0,1));
        // Set up pc=0x20 in RUN for the reset check
        vecs.push_back(mk(1,0,0,0,        0,0,0,          32'h40C,0,1, 0,0));
        vecs.push_back(mk(0,0,1,32'h20,   0,0,0,          32'h0,1,0, 0,0));
        vecs.push_back(mk(0,1,0,0,        0,0,0,          32'h20,0,0, 1,NOP));

        #3;
        chk("rst.pc", 0, pc, 32'h0);
        chk("rst.valid", 0, {31'd0, valid}, 32'd0);
        chk("rst.halt", 0, {31'd0, halt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i], STEP_DFLT, "vec", i);
        end

        // Asynchronous reset mid-cycle at pc=0x20
        @(negedge clk);
        start = 0; stall = 0; redir = 0; wr_en = 0;
        #1;
        chk("pre_rst.pc", 0, pc, 32'h20);
        chk("pre_rst.valid", 0, {31'd0, valid}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst.pc", 0, pc, 32'h0);
        chk("arst.valid", 0, {31'd0, valid}, 32'd0);
        chk("arst.halt", 0, {31'd0, halt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Replay of the retained program (0x8 now holds the halt word)
        drive(mk(1,0,0,0, 0,0,0, 32'h0,0,0, 0,0), STEP_DFLT, "replay", 0);
        drive(mk(0,0,0,0, 0,0,0, 32'h0,1,0, 1,NOP), STEP_DFLT, "replay", 1);
        drive(mk(0,0,0,0, 0,0,0, 32'h4,1,0, 1,NOP), STEP_DFLT, "replay", 2);
        drive(mk(0,0,0,0, 0,0,0, 32'h8,1,0, 1,HALT), STEP_DFLT, "replay", 3);
        drive(idle_v(32'hC,0,1), STEP_DFLT, "replay", 4);

`ifdef IF_STEP_EN
        drive(mk(1,0,0,0, 0,0,0, 32'hC,0,1, 0,0), 1'b0, "step", 0);
        for (int i = 1; i <= 5; i++) begin
            drive(idle_v(32'h0,0,0), 1'b0, "step", i);
        end
        drive(mk(0,0,1,32'h80, 0,0,0, 32'h0,0,0, 0,0), 1'b0, "step", 6);
        drive(idle_v(32'h0,1,0), 1'b1, "step", 7);
        drive(idle_v(32'h4,0,0), 1'b0, "step", 8);
        drive(idle_v(32'h4,1,0), 1'b1, "step", 9);
        drive(idle_v(32'h8,0,0), 1'b0, "step", 10);
        drive(idle_v(32'h8,1,0), 1'b1, "step", 11);
        drive(idle_v(32'hC,0,1), 1'b0, "step", 12);
`else
        // Continuous mode: i_step has no effect
        drive(mk(1,0,0,0, 0,0,0, 32'hC,0,1, 0,0), 1'b1, "nostep", 0);
        drive(idle_v(32'h0,1,0), 1'b0, "nostep", 1);
        drive(idle_v(32'h4,1,0), 1'b1, "nostep", 2);
        drive(idle_v(32'h8,1,0), 1'b0, "nostep", 3);
        drive(idle_v(32'hC,0,1), 1'b0, "nostep", 4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the pipeline: holds the PC, reads the word-addressed instruction memory, and presents instr / pc / pc+4 for the IF/ID register to capture.
- Applies hazard stalls and branch/jump redirects from later stages.
- Exposes a program-load write port to the debug/loader unit.
- Runs a small run-control FSM: idle, run, halted.

Parameters:
- NB_INSTR, 32, instruction width.
- NB_PC, 32, program counter width.
- MEM_DEPTH, 256, instruction memory depth in words (power of two).
- RESET_PC, 32'h0000_0000, PC value loaded on reset and on restart.
- HALT_INSTR, 32'hFFFF_FFFF, encoding that ends program execution.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  pulse; starts execution from RESET_PC.
- i_step  in  1  single-step advance pulse (used only with IF_STEP_EN).
- i_stall  in  1  hazard stall; holds PC.
- i_redirect  in  1  taken branch/jump from a later stage.
- i_redirect_pc  in  NB_PC  redirect target address.
- i_wr_en  in  1  loader write strobe.
- i_wr_addr  in  NB_PC  loader byte address; bits [1:0] ignored.
- i_wr_data  in  NB_INSTR  loader write data.
- o_instr  out  NB_INSTR  instruction at the current PC.
- o_pc  out  NB_PC  current PC.
- o_pc_next  out  NB_PC  o_pc + 4.
- o_valid  out  1  instruction is advancing this cycle.
- o_halt  out  1  FSM is in HALTED.

Behaviour:
- Clock and reset: single clock `clk`; reset `i_rst` is asynchronous and active-high.
- Reset values: state=IDLE, pc=RESET_PC, o_valid=0, o_halt=0. Memory contents are not cleared by reset.
- Memory read: combinational; o_instr = mem[pc[2 +: log2(MEM_DEPTH)]]. Upper PC bits are ignored, so addresses wrap modulo MEM_DEPTH*4.
- PC arithmetic: o_pc_next = pc + 4, modulo 2^NB_PC.
- Memory write: synchronous. Accepted only in IDLE or HALTED. Ignored in RUN.
- "advance" is defined as: state==RUN and i_stall==0.
- o_valid = advance.
- IDLE:
  - pc holds.
  - i_start -> RUN, pc <= RESET_PC.
  - i_redirect is ignored.
- RUN, next-PC priority (highest first):
  - i_redirect=1 -> pc <= i_redirect_pc. Overrides stall and halt; the wrong-path instruction is flushed downstream.
  - else i_stall=1 -> pc holds, o_valid=0.
  - else o_instr==HALT_INSTR -> o_valid=1 for this cycle (the halt word enters the pipeline), pc <= pc+4, state -> HALTED.
  - else pc <= pc+4.
- HALTED:
  - o_halt=1, o_valid=0, pc holds.
  - i_start -> RUN, pc <= RESET_PC.
- i_start while in RUN is ignored.
- Reset mid-operation: immediately returns to IDLE at RESET_PC. Memory is retained, so a new i_start re-runs the loaded program.
- Latency: redirect takes effect on the next edge. The target instruction is presented in the cycle after i_redirect.

Optional Feature:
- Macro: IF_STEP_EN.
- With the macro defined:
  - advance = state==RUN && !i_stall && i_step.
  - Without i_step, pc holds and o_valid=0.
  - Redirect still applies only on an i_step cycle (the whole pipeline is stepped together).
- Without the macro:
  - i_step is ignored.
  - advance = state==RUN && !i_stall (continuous mode).

Decomposition:
- Shared CPU package holds:
  - FSM state encoding: IDLE=2'd0, RUN=2'd1, HALTED=2'd2.
  - HALT_INSTR default.
  - Instruction width constant, shared with if_id_reg and the decoder.
- Sub-module instr_mem: MEM_DEPTH x NB_INSTR array with one synchronous write port and one combinational read port, no reset.
- PC register, next-PC mux and FSM stay in instr_fetch_unit.

Test Plan:
- Load and run: write 0x00000013 to addresses 0x0, 0x4, 0x8 and HALT_INSTR to 0xC, then pulse i_start -> o_pc sequence 0,4,8,C with o_valid=1 each cycle; then o_halt=1, o_pc=0x10, o_valid=0.
- Stall: during RUN at pc=0x4, hold i_stall for 2 cycles -> o_pc stays 0x4 with o_valid=0 for 2 cycles, then advances to 0x8.
- Redirect wins: at pc=0x8, assert i_stall=1 and i_redirect=1 with i_redirect_pc=0x40 together -> next cycle o_pc=0x40 and o_pc_next=0x44. A HALT_INSTR at 0x8 is ignored in that same cycle.
- Write gating and wrap: a write in RUN to 0x0 leaves the word unchanged. With MEM_DEPTH=256, pc=0x400 reads the same word as 0x0.
- Async reset: assert i_rst mid-cycle while pc=0x20 -> o_pc=0x0 and o_valid=0 immediately, without waiting for a clock edge. A new i_start replays the retained program.
- IF_STEP_EN build: in RUN with no i_step for 5 cycles -> pc holds. Three i_step pulses -> pc advances 0 -> 4 -> 8 -> C, with o_valid high only on the step cycles.
